alu_cmd_sequencer: RTL and testbench

- Initiator-side controller for the team's 8-bit combinational ALU (operands A/B, 3-bit opcode, 8-bit result).
- Accepts tagged ALU commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU's A, B and opcode inputs from registers, captures the ALU result one cycle later, and returns it with status flags over a valid/ready response interface.
- Sits between a command source (test harness or control FSM) and the ALU instance.

---
 rtl/alu_cmd_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers tagged ALU commands in a FIFO, issues them one at
// a time to an external combinational 8-bit ALU, captures the result one cycle
// later and returns it with tag and status flags over a valid/ready channel.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op, cmd_tag  command payload
//   alu_a, alu_b, alu_opcode   registered operands/opcode to the ALU
//   alu_out                    combinational ALU result
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_tag          captured result and originating tag
//   rsp_zero, rsp_err          result-is-zero, reserved-opcode flags
//   ops_done                   wrapping count of completed responses
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [15:0]      ops_done
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [2:0]  OP_RSV = 3'b111;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;

  logic [7:0]       alu_a_d, alu_b_d, rsp_data_d;
  logic [2:0]       alu_opcode_d;
  logic [TAG_W-1:0] rsp_tag_d;
  logic             rsp_valid_d, rsp_zero_d, rsp_err_d, cmd_ready_d;
  logic [15:0]      ops_done_d;

  logic push_c, pop_c, empty_c, hs_c;
  cmd_t head_c;

  assign push_c  = cmd_valid && cmd_ready;
  assign empty_c = (count_q == '0);
  assign hs_c    = rsp_valid && rsp_ready;
  assign head_c  = mem[rd_ptr_q];

  // FIFO storage; no reset needed, occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= cmd_t'{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  end

  // Next-state, pop decision and next values of all registered outputs
  always_comb begin
    state_d      = state_q;
    pop_c        = 1'b0;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_opcode_d = alu_opcode;
    tag_d        = tag_q;
    err_d        = err_q;
    rsp_valid_d  = rsp_valid;
    rsp_data_d   = rsp_data;
    rsp_tag_d    = rsp_tag;
    rsp_zero_d   = rsp_zero;
    rsp_err_d    = rsp_err;
    ops_done_d   = ops_done;

    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_out;
        rsp_zero_d  = (alu_out == 8'h00);
        rsp_tag_d   = tag_q;
        rsp_err_d   = err_q;
        state_d     = RESPOND;
      end
      RESPOND: begin
        if (hs_c) begin
          ops_done_d  = ops_done + 16'd1;
          rsp_valid_d = 1'b0;
          if (!empty_c) begin
            pop_c   = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Popped command goes straight onto the ALU inputs
    if (pop_c) begin
      alu_a_d      = head_c.a;
      alu_b_d      = head_c.b;
      alu_opcode_d = head_c.op;
      tag_d        = head_c.tag;
      err_d        = (head_c.op == OP_RSV);
    end
  end

  // Occupancy and registered ready derived from post-edge occupancy
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != CNT_W'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_ready  <= 1'b0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_opcode <= OP_RSV;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_tag    <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      ops_done   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      cmd_ready  <= cmd_ready_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_opcode <= alu_opcode_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_tag    <= rsp_tag_d;
      rsp_zero   <= rsp_zero_d;
      rsp_err    <= rsp_err_d;
      ops_done   <= ops_done_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: behavioural ALU on the alu_* pins, an
// expected-response queue computed from the ALU rules, directed scenarios and
// a randomized traffic/backpressure run.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready;
  logic [7:0]       cmd_a, cmd_b;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a, alu_b, alu_out;
  logic [2:0]       alu_opcode;
  logic             rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [7:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      ops_done;

  typedef struct packed {
    logic [7:0]       d;
    logic [TAG_W-1:0] t;
    logic             z;
    logic             e;
  } rsp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_ops = 0;
  rsp_t exp_q[$];

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'b000:  r = ~a;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = a & b;
      3'b100:  r = {4'h0, a[3:0]} * {4'h0, b[3:0]};
      3'b101:  r = a + b;
      3'b110:  r = a - b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign alu_out = alu_ref(alu_a, alu_b, alu_opcode);

  function automatic rsp_t mk(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                              input logic [TAG_W-1:0] tag);
    rsp_t r;
    r.d = alu_ref(a, b, op);
    r.t = tag;
    r.z = (r.d == 8'h00);
    r.e = (op == 3'b111);
    return r;
  endfunction

  function automatic rsp_t observed();
    rsp_t r;
    r.d = rsp_data;
    r.t = rsp_tag;
    r.z = rsp_zero;
    r.e = rsp_err;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
  endtask

  // Pushes one command into an idle sequencer and collects its response
  task automatic send_and_wait(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                               input logic [TAG_W-1:0] tag, output logic ok, output rsp_t got);
    int w;
    rsp_ready = 1'b0;
    drive_cmd(a, b, op, tag);
    tick();
    cmd_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 20) begin tick(); w++; end
    ok  = rsp_valid;
    got = observed();
    if (ok) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_ops++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({cmd_ready, rsp_valid, ops_done} !== 18'h0) begin
      n_bad++; $display("FAIL reset_ctl: got ready=%b valid=%b ops=%h exp 0/0/0", cmd_ready, rsp_valid, ops_done);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_opcode} !== {8'h00, 8'h00, 3'b111}) begin
      n_bad++; $display("FAIL reset_alu: got a=%h b=%h op=%b exp 00/00/111", alu_a, alu_b, alu_opcode);
    end
    n_cmp++;
    if (observed() !== rsp_t'(0)) begin
      n_bad++; $display("FAIL reset_rsp: got %h exp 0", observed());
    end
    rst_n = 1'b1;
    exp_ops = 0;
    exp_q.delete();
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready: got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    rsp_t e;
    e = mk(8'h0F, 8'h03, 3'b100, 4'd5);
    rsp_ready = 1'b0;
    drive_cmd(8'h0F, 8'h03, 3'b100, 4'd5);
    tick();                                   // E0: push
    cmd_valid = 1'b0;
    tick();                                   // E1: pop into ISSUE
    n_cmp++;
    if ({rsp_valid, alu_a, alu_b, alu_opcode} !== {1'b0, 8'h0F, 8'h03, 3'b100}) begin
      n_bad++; $display("FAIL single_issue: got v=%b a=%h b=%h op=%b exp 0/0f/03/100",
                        rsp_valid, alu_a, alu_b, alu_opcode);
    end
    tick();                                   // E2: response valid
    n_cmp++;
    if (rsp_valid !== 1'b1 || observed() !== e || e.d !== 8'h2D) begin
      n_bad++; $display("FAIL single_rsp: got v=%b %h exp v=1 %h", rsp_valid, observed(), e);
    end
    rsp_ready = 1'b1;
    tick();                                   // E3: handshake
    rsp_ready = 1'b0;
    exp_ops++;
    n_cmp++;
    if ({rsp_valid, ops_done} !== {1'b0, 16'd1} || alu_a !== 8'h0F) begin
      n_bad++; $display("FAIL single_done: got v=%b ops=%0d a=%h exp 0/1/0f", rsp_valid, ops_done, alu_a);
    end
  endtask

  task automatic test_wrap_arith();
    logic [7:0] va [3] = '{8'hF0, 8'h03, 8'hAA};
    logic [7:0] vb [3] = '{8'h20, 8'h05, 8'hAA};
    logic [2:0] vo [3] = '{3'b101, 3'b110, 3'b010};
    logic [7:0] vr [3] = '{8'h10, 8'hFE, 8'h00};
    logic ok;
    rsp_t got, e;
    for (int i = 0; i < 3; i++) begin
      e = mk(va[i], vb[i], vo[i], TAG_W'(i + 1));
      send_and_wait(va[i], vb[i], vo[i], TAG_W'(i + 1), ok, got);
      n_cmp++;
      if (ok !== 1'b1 || got !== e || got.d !== vr[i]) begin
        n_bad++; $display("FAIL wrap_%0d: got ok=%b %h exp %h", i, ok, got, e);
      end
    end
    n_cmp++;
    if (ops_done !== 16'(exp_ops)) begin
      n_bad++; $display("FAIL wrap_ops: got %0d exp %0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_reserved();
    logic ok;
    rsp_t got, e;
    e.d = 8'h00; e.t = 4'hA; e.z = 1'b1; e.e = 1'b1;
    send_and_wait(8'h55, 8'h33, 3'b111, 4'hA, ok, got);
    n_cmp++;
    if (ok !== 1'b1 || got !== e) begin
      n_bad++; $display("FAIL reserved: got ok=%b %h exp %h", ok, got, e);
    end
  endtask

  task automatic test_backpressure();
    int hs_cyc [$];
    int cyc, w;
    rsp_t e;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
        n_bad++; $display("FAIL bp_ready_%0d: got %b exp 1", i, cmd_ready);
      end
      drive_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 6)), TAG_W'(i + 3));
      exp_q.push_back(mk(cmd_a, cmd_b, cmd_op, cmd_tag));
      tick();
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b01) begin
      n_bad++; $display("FAIL bp_full: got ready=%b valid=%b exp 0/1", cmd_ready, rsp_valid);
    end
    // An offered command while full must be ignored
    drive_cmd(8'h77, 8'h11, 3'b101, 4'hF);
    tick(); tick(); tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_hold_full: got %b exp 0", cmd_ready);
    end
    rsp_ready = 1'b1;
    cyc = 0;
    while (hs_cyc.size() < DEPTH + 1 && cyc < 40) begin
      if (rsp_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (observed() !== e) begin
          n_bad++; $display("FAIL bp_rsp_%0d: got %h exp %h", hs_cyc.size(), observed(), e);
        end
        hs_cyc.push_back(cyc);
        exp_ops++;
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (hs_cyc.size() != DEPTH + 1) begin
      n_bad++; $display("FAIL bp_count: got %0d exp %0d", hs_cyc.size(), DEPTH + 1);
    end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      n_cmp++;
      if (hs_cyc[i] - hs_cyc[i-1] != 2) begin
        n_bad++; $display("FAIL bp_spacing_%0d: got %0d exp 2", i, hs_cyc[i] - hs_cyc[i-1]);
      end
    end
    w = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) w++;
      tick();
    end
    rsp_ready = 1'b0;
    n_cmp++;
    if (w != 0 || ops_done !== 16'(exp_ops)) begin
      n_bad++; $display("FAIL bp_after: got extra=%0d ops=%0d exp 0/%0d", w, ops_done, exp_ops);
    end
  endtask

  task automatic test_random();
    rsp_t e;
    int tag_ctr = 0;
    int w;
    for (int cyc = 0; cyc < 400; cyc++) begin
      cmd_valid = ($urandom_range(0, 99) < 60);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_op    = 3'($urandom);
      cmd_tag   = TAG_W'(tag_ctr);
      rsp_ready = ($urandom_range(0, 99) < 65);
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(mk(cmd_a, cmd_b, cmd_op, cmd_tag));
        tag_ctr++;
      end
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_unexpected: got %h exp none", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            n_bad++; $display("FAIL rand_rsp: got %h exp %h", observed(), e);
          end
        end
        exp_ops++;
      end
      tick();
      n_cmp++;
      if (ops_done !== 16'(exp_ops)) begin
        n_bad++; $display("FAIL rand_ops: got %0d exp %0d", ops_done, exp_ops);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      if (rsp_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (observed() !== e) begin
          n_bad++; $display("FAIL rand_drain: got %h exp %h", observed(), e);
        end
        exp_ops++;
      end
      tick();
      w++;
    end
    tick(); tick();
    n_cmp++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0 || ops_done !== 16'(exp_ops)) begin
      n_bad++; $display("FAIL rand_end: got left=%0d valid=%b ops=%0d exp 0/0/%0d",
                        exp_q.size(), rsp_valid, ops_done, exp_ops);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int stale, w;
    rsp_t e;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(8'(8'h10 + i), 8'h01, 3'b101, TAG_W'(i + 1));
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();                                   // handshake: second command now in ISSUE
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, ops_done, alu_a, alu_b, alu_opcode} !== {2'b00, 16'h0, 8'h00, 8'h00, 3'b111}
        || observed() !== rsp_t'(0)) begin
      n_bad++; $display("FAIL midrst_vals: got ready=%b v=%b ops=%0d a=%h b=%h op=%b rsp=%h exp reset values",
                        cmd_ready, rsp_valid, ops_done, alu_a, alu_b, alu_opcode, observed());
    end
    tick(); tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_ops = 0;
    rsp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) stale++;
    end
    n_cmp++;
    if (stale != 0 || ops_done !== 16'h0) begin
      n_bad++; $display("FAIL midrst_stale: got stale=%0d ops=%0d exp 0/0", stale, ops_done);
    end
    rsp_ready = 1'b0;
    e = mk(8'h12, 8'h34, 3'b011, 4'h9);
    drive_cmd(8'h12, 8'h34, 3'b011, 4'h9);
    tick();
    cmd_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 20) begin tick(); w++; end
    n_cmp++;
    if (rsp_valid !== 1'b1 || observed() !== e) begin
      n_bad++; $display("FAIL midrst_fresh: got v=%b %h exp v=1 %h", rsp_valid, observed(), e);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if (ops_done !== 16'd1) begin
      n_bad++; $display("FAIL midrst_ops: got %0d exp 1", ops_done);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap_arith();
    test_reserved();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
